// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//   UART receive front end for the Trivium core. Synchronises the serial
//   line, deframes 8N1 characters (8E1 when UART_RX_PARITY_EN is defined),
//   rejects glitches, framing errors and held-low breaks, and hands clean
//   bytes to the consumer through a small valid/ready FIFO.
//
//   Optional feature macro: UART_RX_PARITY_EN (even parity bit after the
//   data bits, adds the parity_err port). Undefined by default.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ena        receive enable; low aborts the current frame silently
//   serial_in  asynchronous UART line, idle high
//   rx_data    byte at the FIFO head, meaningful while rx_valid=1
//   rx_valid   FIFO not empty
//   rx_ready   consumer accept; pop when rx_valid & rx_ready
//   frame_err  1-cycle pulse, stop bit sampled low
//   overrun    1-cycle pulse, good byte dropped because FIFO was full
//   parity_err 1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       overrun,
  output logic       parity_err
`else
  output logic       overrun
`endif
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  // All flops reset high so an idle line never looks like a start edge.
  // -------------------------------------------------------------------------
  logic sync1;
  logic s;
  logic s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      s_d   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  // -------------------------------------------------------------------------
  // Deframing FSM. The baud counter is loaded with the number of cycles to
  // wait and the line is sampled on the cycle it reads 1, so START samples
  // mid start bit and every later sample lands one bit period further on.
  // push/push_byte are registered and committed to the FIFO one edge later.
  // -------------------------------------------------------------------------
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              push;
  logic [7:0]        push_byte;
  logic              baud_done_c;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  assign baud_done_c = (baud_cnt == BAUD_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_byte <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!ena) begin
        // Abort silently; the partial byte is simply forgotten.
        state    <= ST_IDLE;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (s_d && !s) begin
              state    <= ST_START;
              baud_cnt <= BAUD_W'(HALF_BIT);
            end
          end

          ST_START: begin
            if (baud_done_c) begin
              if (!s) begin
                state    <= ST_DATA;
                baud_cnt <= BAUD_W'(CLKS_PER_BIT);
                bit_idx  <= '0;
              end else begin
                // Line back high at mid start bit: a glitch, not a frame.
                state    <= ST_IDLE;
                baud_cnt <= '0;
              end
            end else begin
              baud_cnt <= baud_cnt - BAUD_W'(1);
            end
          end

          ST_DATA: begin
            if (baud_done_c) begin
              shreg[bit_idx] <= s;
              baud_cnt       <= BAUD_W'(CLKS_PER_BIT);
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              baud_cnt <= baud_cnt - BAUD_W'(1);
            end
          end

`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (baud_done_c) begin
              // Even parity: the parity bit equals the XOR of the data bits.
              par_bad  <= (s != ^shreg);
              state    <= ST_STOP;
              baud_cnt <= BAUD_W'(CLKS_PER_BIT);
            end else begin
              baud_cnt <= baud_cnt - BAUD_W'(1);
            end
          end
`endif

          ST_STOP: begin
            if (baud_done_c) begin
              baud_cnt <= '0;
              if (s) begin
                state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  push      <= 1'b1;
                  push_byte <= shreg;
                end
`else
                push      <= 1'b1;
                push_byte <= shreg;
`endif
              end else begin
                // Framing error outranks parity: one pulse per frame.
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              baud_cnt <= baud_cnt - BAUD_W'(1);
            end
          end

          ST_BREAK: begin
            // Hold off until the line releases so a held-low line
            // cannot retrigger a frame.
            if (s) begin
              state <= ST_IDLE;
            end
          end

          default: begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO. rx_valid mirrors the registered fill level; rx_data is the
  // registered head entry, including the bypass when a byte lands in an
  // empty (or just-emptied) FIFO.
  // -------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             pop_c;
  logic             full_c;
  logic             push_ok_c;
  logic             drop_c;
  logic [PTR_W-1:0] rd_ptr_n_c;
  logic [LVL_W-1:0] level_n_c;
  logic [7:0]       head_c;

  always_comb begin
    pop_c      = rx_valid & rx_ready;
    full_c     = (level == LVL_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs.
    push_ok_c  = push & (~full_c | pop_c);
    drop_c     = push & full_c & ~pop_c;
    rd_ptr_n_c = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    level_n_c  = level + LVL_W'(push_ok_c) - LVL_W'(pop_c);
    head_c     = (push_ok_c && (wr_ptr == rd_ptr_n_c)) ? push_byte : mem[rd_ptr_n_c];
  end

  // Storage array carries no reset; emptiness is tracked by level alone.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_n_c;
      level    <= level_n_c;
      rx_valid <= (level_n_c != '0);
      rx_data  <= head_c;
      overrun  <= drop_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
//   Drives UART frames at a reduced bit period and compares the DUT against
//   a transaction-level reference: each frame's fate (delivered, framing
//   error, parity error, aborted) is decided when the frame is issued and
//   scheduled at its due cycle; a monitor replays those events through a
//   queue model of the FIFO and compares the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

  localparam int B     = 16;
  localparam int H     = B / 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Bit periods from the start edge to the stop-bit decision.
  localparam int NB  = PAR_EN ? 10 : 9;
  localparam int ERR = 2 + H + NB * B;
  localparam int LAT = 3 + H + NB * B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_deframer #(
    .CLKS_PER_BIT(B),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .serial_in (serial_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .overrun   (overrun),
    .parity_err(parity_err)
`else
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Scheduled events (key = clock edge number) and FIFO model.
  logic [7:0] push_at [int];
  bit         ferr_at [int];
  bit         perr_at [int];
  logic [7:0] mq [$];
  logic [7:0] got [$];
  int         ovr_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         rise_cyc = -1;
  bit         valid_d = 1'b0;
  bit         rdy_prev = 1'b0;
  bit         rst_prev = 1'b1;
  int         rdy_mode = 0;

  // Monitor: apply the edge that just happened to the model, then compare.
  always @(negedge clk) begin
    bit pop_m, full_m, ex_ovr, ex_ferr, ex_perr;
    pop_m = 1'b0; full_m = 1'b0; ex_ovr = 1'b0; ex_ferr = 1'b0; ex_perr = 1'b0;
    if (rst_prev) begin
      mq.delete();
    end else begin
      full_m = (mq.size() == DEPTH);
      pop_m  = (mq.size() != 0) && rdy_prev;
      if (pop_m) void'(mq.pop_front());
      if (push_at.exists(cyc)) begin
        if (full_m && !pop_m) ex_ovr = 1'b1;
        else mq.push_back(push_at[cyc]);
      end
      ex_ferr = ferr_at.exists(cyc);
      ex_perr = perr_at.exists(cyc);
    end
    if (push_at.exists(cyc)) push_at.delete(cyc);
    if (ferr_at.exists(cyc)) ferr_at.delete(cyc);
    if (perr_at.exists(cyc)) perr_at.delete(cyc);

    check("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
    check("overrun", 32'(overrun), 32'(ex_ovr));
    check("frame_err", 32'(frame_err), 32'(ex_ferr));
`ifdef UART_RX_PARITY_EN
    check("parity_err", 32'(parity_err), 32'(ex_perr));
    if (parity_err === 1'b1) perr_cnt++;
`else
    if (ex_perr) perr_cnt++;
`endif

    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (rx_valid && !valid_d) rise_cyc = cyc;
    valid_d  = rx_valid;
    rdy_prev = rx_ready;
    rst_prev = rst;
  end

  // Consumer: held low, held high, or random backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) tick();
  endtask

  // Issue one frame; when sched is set, record its expected outcome.
  task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_flip,
                            input bit sched, output int n0);
    n0 = cyc + 1;
    if (sched) begin
      if (!stop_v) ferr_at[n0 + ERR] = 1'b1;
      else if (PAR_EN && par_flip) perr_at[n0 + ERR] = 1'b1;
      else push_at[n0 + LAT] = d;
    end
    serial_in = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (B) tick();
    end
    if (PAR_EN) begin
      serial_in = (^d) ^ par_flip;
      repeat (B) tick();
    end
    serial_in = stop_v;
    repeat (B) tick();
  endtask

  initial begin
    int n0;
    int base;
    logic [7:0] burst [10] = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99, 8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};
    logic [7:0] d;
    bit stop_v, pf;

    rst = 1'b1; ena = 1'b1; serial_in = 1'b1; rdy_mode = 0;
    repeat (4) tick();
    rst = 1'b0;
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    idle(2 * B);

    // Single byte: latency and pop.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, n0);
    idle(B);
    check("latency", 32'(rise_cyc), 32'(n0 + LAT));
    check("single rx_data", 32'(rx_data), 32'hA5);
    rdy_mode = 1;
    idle(4);
    check("single drained", 32'(rx_valid), 32'h0);

    // Back-to-back burst into a stalled consumer.
    rdy_mode = 0;
    idle(4);
    got.delete();
    base = ovr_cnt;
    foreach (burst[i]) send_frame(burst[i], 1'b1, 1'b0, 1'b1, n0);
    idle(B);
    check("burst overruns", 32'(ovr_cnt - base), 32'd6);
    rdy_mode = 1;
    idle(10);
    check("burst drain count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("burst drain order", 32'(got[i]), 32'(burst[i]));
    check("burst empty", 32'(rx_valid), 32'h0);

    // Short low glitch must be ignored.
    got.delete();
    serial_in = 1'b0;
    repeat ($urandom_range(H - 1, 1)) tick();
    idle(2 * B);
    check("glitch no push", 32'(got.size()), 32'd0);

    // Framing error with the line held low afterwards, then recovery.
    base = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, n0);
    serial_in = 1'b0;
    repeat (3 * B) tick();
    idle(B);
    check("frame_err count", 32'(ferr_cnt - base), 32'd1);
    check("frame_err no push", 32'(got.size()), 32'd0);
    send_frame(8'h7F, 1'b1, 1'b0, 1'b1, n0);
    idle(B);
    check("after break count", 32'(got.size()), 32'd1);
    if (got.size() != 0) check("after break byte", 32'(got[0]), 32'h7F);

    // Enable dropped mid-frame: only the following byte is delivered.
    rdy_mode = 0;
    got.delete();
    fork
      send_frame(8'hC1, 1'b1, 1'b0, 1'b0, n0);
      begin
        repeat (H + 3 * B) tick();
        ena = 1'b0;
      end
    join
    idle(B);
    ena = 1'b1;
    idle(B);
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, n0);
    idle(B);
    rdy_mode = 1;
    idle(4);
    check("ena abort count", 32'(got.size()), 32'd1);
    if (got.size() != 0) check("ena abort byte", 32'(got[0]), 32'h99);

`ifdef UART_RX_PARITY_EN
    rdy_mode = 0;
    got.delete();
    base = perr_cnt;
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, n0);
    idle(B);
    send_frame(8'h42, 1'b1, 1'b1, 1'b1, n0);
    idle(B);
    rdy_mode = 1;
    idle(4);
    check("parity_err count", 32'(perr_cnt - base), 32'd1);
    check("parity push count", 32'(got.size()), 32'd1);
    if (got.size() != 0) check("parity good byte", 32'(got[0]), 32'h99);
`endif

    // Randomised traffic with random backpressure.
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      d      = 8'($urandom);
      stop_v = ($urandom_range(9, 0) != 0);
      pf     = PAR_EN && ($urandom_range(5, 0) == 0);
      send_frame(d, stop_v, pf, 1'b1, n0);
      if (!stop_v) begin
        serial_in = 1'b0;
        repeat ($urandom_range(B, 0)) tick();
        idle(B);
      end else begin
        idle($urandom_range(2 * B, 0));
      end
    end

    // Reset in the middle of a frame with bytes waiting in the FIFO.
    rdy_mode = 0;
    idle(B);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, n0);
    send_frame(8'hE1, 1'b1, 1'b0, 1'b1, n0);
    serial_in = 1'b0;
    repeat (B + 3 * B + 3) tick();
    serial_in = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("mid reset rx_valid", 32'(rx_valid), 32'h0);
    idle(B);
    got.delete();
    send_frame(8'h6B, 1'b1, 1'b0, 1'b1, n0);
    idle(B);
    rdy_mode = 1;
    idle(4);
    check("post reset count", 32'(got.size()), 32'd1);
    if (got.size() != 0) check("post reset byte", 32'(got[0]), 32'h6B);

    idle(4 * B);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
